inst_stream_loader: RTL and testbench
=====================================

INST_STREAM_LOADER -- requirements
Module: inst_stream_loader

Interface
REQ-001 Parameter RegAddrWidth, default 32, sets the instruction word and address width.
REQ-002 Parameter InstMemDepth, default 128, sets the number of instruction memory entries; InstMemAddrWidth = $clog2(InstMemDepth).
REQ-003 clk_i  in  1  clock; all state updates on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 clr_i  in  1  synchronous clear.
REQ-006 load_start_i  in  1  request a load of load_len_i words starting at load_base_addr_i.
REQ-007 load_base_addr_i  in  RegAddrWidth  first instruction memory address to write.
REQ-008 load_len_i  in  RegAddrWidth  number of words to load.
REQ-009 in_data_i  in  RegAddrWidth  incoming instruction word.
REQ-010 in_valid_i / in_ready_o  in / out  1 / 1  stream handshake; a word transfers when both are high on a rising edge.
REQ-011 inst_wr_mode_o, inst_wr_addr_en_o, inst_wr_data_en_o  out  1 each  write controls to the instruction control stage.
REQ-012 inst_wr_addr_o, inst_wr_data_o  out  RegAddrWidth each  write address and write data to the instruction control stage.
REQ-013 busy_o  out  1  load in progress; done_o  out  1  one-cycle completion pulse; err_o  out  1  sticky range error.
REQ-014 checksum_o  out  RegAddrWidth  XOR of all words written by the last load.

Function
REQ-015 FSM states: IDLE, SET_ADDR, WRITE, DONE.
REQ-016 IDLE: on load_start_i with base+len <= InstMemDepth, computed at RegAddrWidth+1 bits with no wrap, capture base and len, clear err_o, and go to SET_ADDR; if len == 0, go directly to DONE.
REQ-017 IDLE: on load_start_i with base+len > InstMemDepth, set err_o, stay in IDLE, and issue no write.
REQ-018 SET_ADDR lasts exactly one cycle: inst_wr_addr_en_o=1, inst_wr_addr_o=captured base; next state is WRITE.
REQ-019 WRITE: in_ready_o=1; in_ready_o=0 in every other state.
REQ-020 On each handshake: register in_data_i into inst_wr_data_o; pulse inst_wr_data_en_o for exactly one cycle, the cycle after the handshake; decrement the remaining-count.
REQ-021 WRITE holds while in_valid_i=0, with no writes and no timeout.
REQ-022 On the handshake that brings remaining to 0, go to DONE; the final inst_wr_data_en_o pulse coincides with the DONE cycle.
REQ-023 DONE lasts exactly one cycle with done_o=1, then the FSM returns to IDLE.
REQ-024 inst_wr_mode_o=1 in SET_ADDR, WRITE and DONE, and 0 in IDLE.
REQ-025 busy_o=1 in every state except IDLE.
REQ-026 load_start_i is ignored when the FSM is not in IDLE.
REQ-027 inst_wr_addr_en_o and inst_wr_data_en_o are never high in the same cycle.
REQ-028 Between SET_ADDR and DONE the loader issues exactly len data-enable pulses.
REQ-029 clr_i, in any state, returns the FSM to IDLE next cycle, zeroes all outputs, counters and err_o, and drops any partially received word.

Reset
REQ-030 rst_ni low forces state IDLE and drives every output and internal register to 0.
REQ-031 Reset mid-load leaves no pending write pulse after release.

Configuration
REQ-032 Macro INST_LOADER_CHECKSUM_EN defined: checksum_o is cleared at the accepted start and XOR-accumulates each handshaken word; it holds its value from DONE until the next accepted start or clr_i.
REQ-033 Macro INST_LOADER_CHECKSUM_EN undefined: checksum_o is tied to 0 and no accumulator exists.

Verification
REQ-034 start, base=4, len=3, words A,B,C with in_valid_i always high -> addr_en pulse with addr=4, then three data_en pulses carrying A,B,C; done_o one cycle after the last handshake; busy_o falls next cycle.
REQ-035 base=0, len=2, in_valid_i low for 5 cycles between words -> exactly 2 data_en pulses, in_ready_o high throughout WRITE, done_o once.
REQ-036 base=126, len=3 with InstMemDepth=128 -> err_o=1, no addr_en or data_en, busy_o stays 0; a following valid start clears err_o.
REQ-037 len=0 -> done_o pulses 1 cycle after start, no write pulses, inst_wr_mode_o high for the DONE cycle only.
REQ-038 clr_i asserted after 1 of 4 words, plus a second start while busy -> second start ignored; after clr_i all outputs are 0 and the FSM is in IDLE; a new load of len=2 completes normally.
REQ-039 With INST_LOADER_CHECKSUM_EN defined, words 0x0F,0xF0,0xFF -> checksum_o=0x00; words 0x01,0x02 -> 0x03; with the macro undefined, checksum_o=0 always.

Source files
------------

// File: rtl/inst_stream_loader.sv
// Streams instruction words into the instruction control stage: one address-set cycle, then one
// data-enable pulse per accepted word. Optional checksum via INST_LOADER_CHECKSUM_EN.
module inst_stream_loader #(
  parameter int unsigned RegAddrWidth = 32,
  parameter int unsigned InstMemDepth = 128
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    load_start_i,
  input  logic [RegAddrWidth-1:0] load_base_addr_i,
  input  logic [RegAddrWidth-1:0] load_len_i,
  input  logic [RegAddrWidth-1:0] in_data_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic                    inst_wr_mode_o,
  output logic                    inst_wr_addr_en_o,
  output logic                    inst_wr_data_en_o,
  output logic [RegAddrWidth-1:0] inst_wr_addr_o,
  output logic [RegAddrWidth-1:0] inst_wr_data_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [RegAddrWidth-1:0] checksum_o
);

  localparam int unsigned InstMemAddrWidth = $clog2(InstMemDepth);
  // An accepted length never exceeds InstMemDepth, so one extra bit suffices.
  localparam int unsigned CntWidth = InstMemAddrWidth + 1;
  localparam logic [RegAddrWidth:0] MemDepth = (RegAddrWidth+1)'(InstMemDepth);

  typedef enum logic [1:0] {IDLE, SET_ADDR, WRITE, DONE} state_e;

  state_e                  state_q, state_d;
  logic [RegAddrWidth-1:0] base_q, base_d;
  logic [RegAddrWidth-1:0] wr_data_q, wr_data_d;
  logic [CntWidth-1:0]     rem_q, rem_d;
  logic                    err_q, err_d;
  logic                    wr_en_q, wr_en_d;
  logic [RegAddrWidth:0]   end_addr;
  logic                    range_ok, start_ok, hs;

  // Widened sum so a huge base or length cannot wrap into range.
  assign end_addr = {1'b0, load_base_addr_i} + {1'b0, load_len_i};
  assign range_ok = (end_addr <= MemDepth);
  assign start_ok = (state_q == IDLE) && load_start_i && range_ok;
  assign hs       = (state_q == WRITE) && in_valid_i;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    rem_d     = rem_q;
    err_d     = err_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_start_i) begin
          if (range_ok) begin
            base_d  = load_base_addr_i;
            rem_d   = load_len_i[CntWidth-1:0];
            err_d   = 1'b0;
            state_d = (load_len_i == '0) ? DONE : SET_ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SET_ADDR: state_d = WRITE;
      WRITE: begin
        if (in_valid_i) begin
          wr_data_d = in_data_i;
          wr_en_d   = 1'b1;
          rem_d     = rem_q - 1'b1;
          if (rem_q == CntWidth'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Clear wins over everything, including a word handshaking this cycle.
    if (clr_i) begin
      state_d   = IDLE;
      base_d    = '0;
      rem_d     = '0;
      err_d     = 1'b0;
      wr_data_d = '0;
      wr_en_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      base_q    <= '0;
      rem_q     <= '0;
      err_q     <= 1'b0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  logic [RegAddrWidth-1:0] cks_q, cks_d;

  always_comb begin
    cks_d = cks_q;
    if (start_ok)  cks_d = '0;
    else if (hs)   cks_d = cks_q ^ in_data_i;
    if (clr_i)     cks_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cks_q <= '0;
    else         cks_q <= cks_d;
  end

  assign checksum_o = cks_q;
`else
  logic unused_cks;
  assign unused_cks = start_ok ^ hs;
  assign checksum_o = '0;
`endif

  assign in_ready_o        = (state_q == WRITE);
  assign inst_wr_mode_o    = (state_q != IDLE);
  assign busy_o            = (state_q != IDLE);
  assign done_o            = (state_q == DONE);
  assign inst_wr_addr_en_o = (state_q == SET_ADDR);
  assign inst_wr_addr_o    = base_q;
  assign inst_wr_data_en_o = wr_en_q;
  assign inst_wr_data_o    = wr_data_q;
  assign err_o             = err_q;

endmodule

// File: tb/tb_inst_stream_loader.sv
// Randomized load scenarios checked against a transaction-level model of the loader.
module tb_inst_stream_loader;
  localparam int W     = 32;
  localparam int DEPTH = 128;
  localparam int BUDGET = 400;

  logic clk, rst_n, clr, load_start, in_valid;
  logic [W-1:0] load_base, load_len, in_data;
  logic ready, mode, addr_en, data_en, busy, done, err;
  logic [W-1:0] wr_addr, wr_data, checksum;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] words_q[$];
  logic [W-1:0] ck_model = '0;

  inst_stream_loader #(.RegAddrWidth(W), .InstMemDepth(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_start_i(load_start),
    .load_base_addr_i(load_base), .load_len_i(load_len), .in_data_i(in_data),
    .in_valid_i(in_valid), .in_ready_o(ready), .inst_wr_mode_o(mode),
    .inst_wr_addr_en_o(addr_en), .inst_wr_data_en_o(data_en),
    .inst_wr_addr_o(wr_addr), .inst_wr_data_o(wr_data), .busy_o(busy),
    .done_o(done), .err_o(err), .checksum_o(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7+3*W-1:0] all_outs();
    return {busy, done, err, mode, addr_en, data_en, ready, wr_addr, wr_data, checksum};
  endfunction

  // Drives one load request and checks the whole observed transaction against the model.
  task automatic run_load(input int unsigned base, input int unsigned len,
                          input int unsigned gap_lo, input int unsigned gap_hi, input bit preset);
    logic [W-1:0] words[$];
    logic [W-1:0] got[$];
    logic [W-1:0] ck, addr_v;
    bit exp_err, in_win, fin, tmo, busy_end, mode_end;
    int n_addr, n_done, n_busy, n_mode, ovl, rviol, done_cyc, last_de, cyc, idx, gap;
    words = {}; got = {};
    ck = '0; addr_v = '0;
    n_addr = 0; n_done = 0; n_busy = 0; n_mode = 0; ovl = 0; rviol = 0;
    done_cyc = 0; last_de = 0; cyc = 0; idx = 0;
    in_win = 0; fin = 0; tmo = 0; busy_end = 1; mode_end = 1;
    exp_err = (longint'(base) + longint'(len) > longint'(DEPTH));
    if (!exp_err) begin
      for (int i = 0; i < int'(len); i++) begin
        words.push_back(preset ? words_q[i] : $urandom());
        ck ^= words[i];
      end
`ifdef INST_LOADER_CHECKSUM_EN
      ck_model = ck;
`endif
    end
    @(negedge clk);
    load_start = 1'b1; load_base = base; load_len = len; in_valid = 1'b0;
    gap = $urandom_range(gap_lo, gap_hi);
    while (!fin) begin
      @(negedge clk);
      cyc++;
      load_start = 1'b0;
      if (data_en) begin got.push_back(wr_data); last_de = cyc; end
      if (addr_en && data_en) ovl++;
      if (busy) n_busy++;
      if (mode) n_mode++;
      if (done) begin n_done++; done_cyc = cyc; in_win = 0; end
      else if (in_win && !ready) rviol++;
      if (addr_en) begin n_addr++; addr_v = wr_addr; in_win = 1; end
      if (done_cyc > 0 && cyc == done_cyc + 1) begin
        fin = 1; busy_end = busy; mode_end = mode;
      end
      if (exp_err && cyc == 4) fin = 1;
      if (cyc >= BUDGET) begin fin = 1; tmo = 1; end
      if (!fin && idx < int'(len)) begin
        if (gap > 0) begin in_valid = 1'b0; gap--; end
        else begin
          in_valid = 1'b1; in_data = words[idx];
          if (ready) begin idx++; gap = $urandom_range(gap_lo, gap_hi); end
        end
      end else in_valid = 1'b0;
    end
    in_valid = 1'b0;

    total++;
    if (err !== exp_err) begin bad++; $display("FAIL err base=%0d len=%0d: got %b want %b", base, len, err, exp_err); end
    total++;
    if (checksum !== ck_model) begin bad++; $display("FAIL checksum: got %h want %h", checksum, ck_model); end
    if (exp_err) begin
      total++;
      if (n_addr != 0 || got.size() != 0 || n_done != 0 || n_busy != 0) begin
        bad++; $display("FAIL err_quiet: got addr=%0d data=%0d done=%0d busy=%0d want all 0",
                        n_addr, got.size(), n_done, n_busy);
      end
    end else begin
      total++;
      if (tmo) begin bad++; $display("FAIL timeout base=%0d len=%0d: no done within %0d cycles", base, len, BUDGET); end
      total++;
      if (n_done != 1) begin bad++; $display("FAIL done_count: got %0d want 1", n_done); end
      total++;
      if (n_addr != (len > 0 ? 1 : 0)) begin bad++; $display("FAIL addr_en_count: got %0d want %0d", n_addr, (len > 0 ? 1 : 0)); end
      if (len > 0) begin
        total++;
        if (addr_v !== W'(base)) begin bad++; $display("FAIL wr_addr: got %0d want %0d", addr_v, base); end
        total++;
        if (last_de != done_cyc) begin bad++; $display("FAIL last_data_at_done: got cycle %0d want %0d", last_de, done_cyc); end
      end else begin
        total++;
        if (done_cyc != 1) begin bad++; $display("FAIL zero_len_done_cycle: got %0d want 1", done_cyc); end
      end
      total++;
      if (got.size() != int'(len)) begin bad++; $display("FAIL data_en_count: got %0d want %0d", got.size(), len); end
      for (int i = 0; i < int'(len) && i < got.size(); i++) begin
        total++;
        if (got[i] !== words[i]) begin bad++; $display("FAIL data_word[%0d]: got %h want %h", i, got[i], words[i]); end
      end
      if (gap_hi == 0 && len > 0) begin
        total++;
        if (done_cyc != int'(len) + 2) begin bad++; $display("FAIL done_latency: got %0d want %0d", done_cyc, len + 2); end
      end
      total++;
      if (ovl != 0 || rviol != 0) begin bad++; $display("FAIL overlap_or_ready: got ovl=%0d ready_drops=%0d want 0", ovl, rviol); end
      total++;
      if (n_mode != done_cyc || busy_end !== 1'b0 || mode_end !== 1'b0) begin
        bad++; $display("FAIL mode_busy_window: got mode_cycles=%0d busy_end=%b mode_end=%b want %0d,0,0",
                        n_mode, busy_end, mode_end, done_cyc);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; load_start = 1'b0; in_valid = 1'b0;
    load_base = '0; load_len = '0; in_data = '0;
    #12;
    total++;
    if (all_outs() !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", all_outs()); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (all_outs() !== '0) begin bad++; $display("FAIL post_reset_idle: got %h want 0", all_outs()); end
  endtask

  task automatic test_basic();
    words_q = '{32'hA, 32'hB, 32'hC};
    run_load(4, 3, 0, 0, 1);
  endtask

  task automatic test_gaps();
    run_load(0, 2, 5, 5, 0);
  endtask

  task automatic test_range_err();
    run_load(126, 3, 0, 0, 0);
    run_load(2, 32'hFFFF_FFFF, 0, 0, 0);
    run_load(125, 3, 0, 1, 0);
  endtask

  task automatic test_zero_len();
    run_load(DEPTH, 0, 0, 0, 0);
    run_load(7, 0, 0, 0, 0);
  endtask

  task automatic test_clear();
    @(negedge clk);
    load_start = 1'b1; load_base = 10; load_len = 4;
    @(negedge clk);
    load_start = 1'b0; in_valid = 1'b1; in_data = $urandom();
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (data_en !== 1'b1) begin bad++; $display("FAIL clr_first_word: got data_en=%b want 1", data_en); end
    load_start = 1'b1; load_base = 0; load_len = 1;
    @(negedge clk);
    load_start = 1'b0;
    total++;
    if (addr_en !== 1'b0 || ready !== 1'b1) begin
      bad++; $display("FAIL start_ignored_busy: got addr_en=%b ready=%b want 0,1", addr_en, ready);
    end
    in_valid = 1'b1; in_data = $urandom(); clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0; ck_model = '0;
    total++;
    if (all_outs() !== '0) begin bad++; $display("FAIL after_clr: got %h want 0", all_outs()); end
    @(negedge clk);
    total++;
    if (all_outs() !== '0) begin bad++; $display("FAIL clr_no_pending: got %h want 0", all_outs()); end
    run_load(20, 2, 0, 1, 0);
  endtask

  task automatic test_reset_midload();
    @(negedge clk);
    load_start = 1'b1; load_base = 40; load_len = 3;
    @(negedge clk);
    load_start = 1'b0; in_valid = 1'b1; in_data = $urandom();
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b1; ck_model = '0;
    @(negedge clk);
    total++;
    if (all_outs() !== '0) begin bad++; $display("FAIL reset_midload: got %h want 0", all_outs()); end
    run_load(60, 3, 0, 2, 0);
  endtask

  task automatic test_checksum();
    logic [W-1:0] want;
    words_q = '{32'h0F, 32'hF0, 32'hFF};
    run_load(30, 3, 0, 1, 1);
    total++;
    if (checksum !== 32'h0) begin bad++; $display("FAIL checksum_0f_f0_ff: got %h want 0", checksum); end
    words_q = '{32'h01, 32'h02};
    run_load(50, 2, 0, 0, 1);
`ifdef INST_LOADER_CHECKSUM_EN
    want = 32'h3;
`else
    want = 32'h0;
`endif
    total++;
    if (checksum !== want) begin bad++; $display("FAIL checksum_01_02: got %h want %h", checksum, want); end
    run_load(127, 2, 0, 0, 0);
    total++;
    if (checksum !== want) begin bad++; $display("FAIL checksum_hold_on_err: got %h want %h", checksum, want); end
  endtask

  task automatic test_random();
    int unsigned b, l;
    for (int i = 0; i < 25; i++) begin
      l = $urandom_range(0, 6);
      b = (i % 5 == 0) ? DEPTH - l : $urandom_range(0, DEPTH + 2);
      run_load(b, l, 0, $urandom_range(0, 3), 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_range_err();
    test_zero_len();
    test_clear();
    test_reset_midload();
    test_checksum();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
